// File: rtl/clk_div_multi.sv
// clk_div_multi: multi-channel programmable clock divider with toggle, pulse and push-button step modes.
module clk_div_multi #(
  parameter int NUM_CH       = 4,
  parameter int CNT_W        = 26,
  parameter int DEFAULT_DIV  = 25000000,
  parameter int DEFAULT_MODE = 0,
  parameter int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk50MHz,
  input  logic              reset,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic [1:0]        cfg_mode,
  input  logic              step,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);
  typedef enum logic [1:0] {M_TOGGLE, M_PULSE, M_STEP, M_RSVD} mode_t;
  logic s1, s2, s3, step_edge;
  always_ff @(posedge clk50MHz or negedge reset)
    if (!reset) {s1, s2, s3} <= '0;
    else {s1, s2, s3} <= {step, s1, s2};
  assign step_edge = s2 & ~s3;
  genvar i;
  for (i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt, div, div_m1, cnt_nx;
    mode_t mode;
    logic run, ev, wr, co, tk, co_nx, tk_nx;
    always_comb begin
      div_m1 = div - CNT_W'(1);
      run    = ch_en[i] && div != '0 && (mode == M_TOGGLE || mode == M_PULSE);
      ev     = run && cnt == div_m1;
      cnt_nx = (mode == M_STEP || ev) ? '0 : run ? cnt + CNT_W'(1) : cnt;
      tk_nx  = ev || (mode == M_STEP && step_edge && ch_en[i]);
      co_nx  = mode == M_PULSE ? ev : tk_nx ? ~co : co;
      wr     = cfg_we && cfg_ch == CH_W'(i);
    end
    // a config write restarts the channel and overrides any event due this cycle
    always_ff @(posedge clk50MHz or negedge reset)
      if (!reset) begin
        cnt  <= '0;
        div  <= CNT_W'(DEFAULT_DIV);
        mode <= mode_t'(2'(DEFAULT_MODE));
        co   <= 1'b0;
        tk   <= 1'b0;
      end else if (wr) begin
        cnt  <= '0;
        div  <= cfg_div;
        mode <= mode_t'(cfg_mode);
        co   <= 1'b0;
        tk   <= 1'b0;
      end else begin
        cnt  <= cnt_nx;
        co   <= co_nx;
        tk   <= tk_nx;
      end
    assign clk_out[i] = co;
    assign tick[i]    = tk;
  end
endmodule

// File: tb/tb_clk_div_multi.sv
// tb_clk_div_multi: scoreboard bench; stimulus queues expected tick events, a monitor pops them on each tick.
module tb_clk_div_multi;
  logic       clk50MHz = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] ch_en = 2'b11;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_ch = '0;
  logic [7:0] cfg_div = '0;
  logic [1:0] cfg_mode = '0;
  logic       step = 1'b0;
  logic [1:0] clk_out, tick;
  logic [1:0] mon_en = 2'b00;
  int cyc = 0, checks = 0, failures = 0;
  typedef struct {int cy; bit v;} ev_t;
  ev_t q0[$], q1[$];

  clk_div_multi #(.NUM_CH(2), .CNT_W(8), .DEFAULT_DIV(5), .DEFAULT_MODE(0), .CH_W(2)) dut (
    .clk50MHz(clk50MHz), .reset(reset), .ch_en(ch_en), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .cfg_mode(cfg_mode), .step(step), .clk_out(clk_out), .tick(tick));

  always #5 clk50MHz = ~clk50MHz;
  always @(posedge clk50MHz) cyc++;

  always @(posedge clk50MHz) begin
    #1;
    for (int c = 0; c < 2; c++) if (mon_en[c] && tick[c]) begin
      automatic ev_t e;
      automatic int n = (c == 0) ? q0.size() : q1.size();
      checks++;
      if (n == 0) begin
        failures++;
        $display("FAIL tick_unexpected ch%0d cyc=%0d clk_out=%0b", c, cyc, clk_out[c]);
      end else begin
        e = (c == 0) ? q0.pop_front() : q1.pop_front();
        if (e.cy != cyc || e.v != clk_out[c]) begin
          failures++;
          $display("FAIL tick_event ch%0d got cyc=%0d clk_out=%0b required cyc=%0d clk_out=%0b",
                   c, cyc, clk_out[c], e.cy, e.v);
        end
      end
    end
  end

  task automatic push(input int c, input int cy, input bit v);
    ev_t e;
    e.cy = cy;
    e.v  = v;
    if (c == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic drain(input int c);
    int n = (c == 0) ? q0.size() : q1.size();
    checks++;
    if (n != 0) begin
      failures++;
      $display("FAIL drain_ch%0d pending=%0d required=0", c, n);
    end
    if (c == 0) q0.delete(); else q1.delete();
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic wr(input int c, input int d, input int m);
    cfg_we   = 1'b1;
    cfg_ch   = 2'(c);
    cfg_div  = 8'(d);
    cfg_mode = 2'(m);
    @(negedge clk50MHz);
    cfg_we   = 1'b0;
  endtask

  initial begin
    int c0, w, x, y, r;
    // test 1: reset then default divide-by-5 toggle on both channels
    #1 chk("reset_async_clk_out", clk_out, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk50MHz);
      chk("reset_clk_out", clk_out, 0);
      chk("reset_tick", tick, 0);
    end
    reset = 1'b1;
    c0 = cyc;
    for (int c = 0; c < 2; c++) begin
      push(c, c0 + 5, 1); push(c, c0 + 10, 0); push(c, c0 + 15, 1); push(c, c0 + 20, 0);
    end
    mon_en = 2'b11;
    repeat (20) @(negedge clk50MHz);
    drain(0); drain(1);
    // test 2: ch1 pulse every 3, ch0 keeps its phase
    wr(1, 3, 1);
    w = cyc;
    push(1, w + 3, 1); push(1, w + 6, 1); push(1, w + 9, 1);
    push(0, c0 + 25, 1); push(0, c0 + 30, 0);
    repeat (9) @(negedge clk50MHz);
    drain(0); drain(1);
    mon_en[1] = 1'b0;
    // test 3: div=1 toggles every cycle, then div=0 stalls low
    wr(0, 1, 0);
    w = cyc;
    for (int k = 1; k <= 6; k++) push(0, w + k, k[0]);
    repeat (6) @(negedge clk50MHz);
    wr(0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk50MHz);
      chk("stall_clk_out0", clk_out[0], 0);
      chk("stall_tick0", tick[0], 0);
    end
    drain(0);
    // test 4: step mode, one tick per press regardless of hold length
    wr(0, 5, 2);
    x = cyc;
    step = 1'b1;
    push(0, x + 3, 1); push(0, x + 13, 0);
    repeat (5) @(negedge clk50MHz);
    chk("step_clk_out_high", clk_out[0], 1);
    @(negedge clk50MHz);
    step = 1'b0;
    repeat (4) @(negedge clk50MHz);
    step = 1'b1;
    @(negedge clk50MHz);
    step = 1'b0;
    repeat (5) @(negedge clk50MHz);
    chk("step_clk_out_low", clk_out[0], 0);
    drain(0);
    // test 5: disable at cnt=2 for 10 cycles, resume from held count
    wr(0, 5, 0);
    y = cyc;
    repeat (2) @(negedge clk50MHz);
    ch_en = 2'b10;
    push(0, y + 15, 1); push(0, y + 20, 0); push(0, y + 25, 1);
    repeat (5) @(negedge clk50MHz);
    chk("disabled_tick0", tick[0], 0);
    chk("disabled_clk_out0", clk_out[0], 0);
    repeat (5) @(negedge clk50MHz);
    ch_en = 2'b11;
    repeat (15) @(negedge clk50MHz);
    chk("pre_reset_clk_out0", clk_out[0], 1);
    drain(0);
    // test 6: async reset between edges, then an out-of-range config write
    #2 reset = 1'b0;
    #1 chk("midreset_clk_out", clk_out, 0);
    chk("midreset_tick", tick, 0);
    @(negedge clk50MHz);
    chk("held_reset_clk_out", clk_out, 0);
    reset = 1'b1;
    r = cyc;
    for (int c = 0; c < 2; c++) begin
      push(c, r + 5, 1); push(c, r + 10, 0);
    end
    mon_en = 2'b11;
    repeat (2) @(negedge clk50MHz);
    wr(3, 1, 1);
    repeat (7) @(negedge clk50MHz);
    drain(0); drain(1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
Parametrised multi-channel clock-enable and divided-clock generator for the pipeline board. It supersedes the single fixed-rate divider. Each of NUM_CH channels has a run-time programmable divisor and mode: free-running square wave, single-cycle pulse, or manual single-step from a push-button for stepping the pipeline one cycle at a time. All channels run in the clk50MHz domain and feed the pipeline clock-enable and display-refresh logic.

Parameters:
NUM_CH, 4, number of independent channels (>=1)
CNT_W, 26, counter and divisor width in bits
DEFAULT_DIV, 25000000, divisor loaded at reset (1 Hz square wave at 50 MHz in toggle mode); must be < 2^CNT_W
DEFAULT_MODE, 0, mode loaded at reset (0 toggle, 1 pulse, 2 step, 3 reserved)
CH_W, max(1,clog2(NUM_CH)), width of channel select

Ports:
clk50MHz  input  1  single system clock
reset  input  1  asynchronous, active-low reset
ch_en  input  NUM_CH  per-channel run enable
cfg_we  input  1  config write strobe, one cycle
cfg_ch  input  CH_W  channel selected by write
cfg_div  input  CNT_W  divisor to load
cfg_mode  input  2  mode to load
step  input  1  raw push-button, asynchronous to clk50MHz
clk_out  output  NUM_CH  divided clock (toggle) or pulse copy
tick  output  NUM_CH  one-cycle enable strobe per channel event

Behaviour:
- Reset (reset=0, async, no clock needed): per channel cnt=0, div=DEFAULT_DIV, mode=DEFAULT_MODE, clk_out=0, tick=0; step sync flops s1,s2,s3=0.
- Per channel state: cnt[CNT_W], div[CNT_W], mode[2], clk_out, tick. All outputs are registered.
- Free-run count (mode 0 or 1, ch_en=1, div!=0), on each edge:
  - if cnt==div-1: cnt<=0 and an event occurs.
  - else cnt<=cnt+1.
  - div-1 is computed in CNT_W bits. div=2^CNT_W-1 is legal.
- Event, mode 0 (toggle): clk_out<=~clk_out, tick<=1. Period of clk_out is 2*div cycles. With div=1, clk_out toggles every cycle and tick is held high.
- Event, mode 1 (pulse): tick<=1, clk_out<=1. Otherwise both <=0. clk_out equals tick.
- In every non-event cycle, tick<=0.
- First event after reset or config write occurs at the div-th edge (cnt runs 0..div-1).
- div=0: channel stalls. cnt holds, tick=0, clk_out holds.
- ch_en=0: cnt and clk_out hold, tick=0. Counting resumes from the held cnt when ch_en=1 again.
- Mode 2 (step):
  - cnt held at 0.
  - step passes through the s1->s2->s3 synchroniser. edge = s2 & ~s3.
  - If edge=1 and ch_en=1: tick<=1 and clk_out toggles.
  - tick rises at the 3rd edge after step is first sampled high and lasts exactly 1 cycle, however long step is held.
  - All step-mode channels share the same edge.
- Mode 3 (reserved): behaves as stall (tick=0, outputs hold).
- Config write (cfg_we=1, cfg_ch<NUM_CH), at the next edge for that channel: div<=cfg_div, mode<=cfg_mode, cnt<=0, clk_out<=0, tick<=0.
  - The write takes priority over any event in the same cycle.
  - Other channels are unaffected.
  - cfg_ch>=NUM_CH: write ignored.
- No debounce inside the block. Bounce on step yields multiple ticks by design; debounce sits upstream.
- Reset asserted mid-count: all state returns immediately to reset values. The first event after release is at the DEFAULT_DIV-th edge.

Test Plan:
(bench uses NUM_CH=2, CNT_W=8, DEFAULT_DIV=5, DEFAULT_MODE=0)
1. Reset low 3 cycles, then release with ch_en=11 -> all outputs 0 during reset; clk_out[0] rises after 5th edge, period 10 cycles; tick[0] high 1 cycle every 5.
2. Write ch1 div=3 mode=1 -> tick[1] and clk_out[1] high 1 cycle every 3 edges, first at 3rd edge after write; ch0 unaffected.
3. Write ch0 div=1 mode=0 -> clk_out[0] toggles every cycle, tick[0] constant 1. Then write div=0 -> clk_out[0]=0, tick[0]=0 and both stay there.
4. Write ch0 mode=2, hold step high 6 cycles, then low 4, then high 1 -> exactly two tick[0] pulses, each 3 edges after the step rise; clk_out[0] goes 0->1->0.
5. Run ch0 at div=5; drop ch_en[0] when cnt=2 and hold low 10 cycles -> no ticks while low; after re-enable, the event occurs on the 3rd edge.
6. Assert reset between edges mid-count -> outputs 0 before the next edge. Also issue cfg_we with cfg_ch=3 -> no channel changes.
